mem_ctrl: RTL

- Responder end of the LSB memory-request interface; sole owner of the byte-wide RAM port.
- Serves three clients:
  - LSB loads: size 1/2/4, signed/unsigned.
  - ROB-committed stores.
  - Fetcher 32-bit instruction reads.
- Serializes each request into per-byte RAM accesses and returns one response pulse per request.

---
 rtl/mem_ctrl_pkg.sv | 27 ++
 rtl/mem_byte_assemble.sv | 27 ++
 rtl/mem_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the memory controller: FSM states, client select, I/O base and helpers.
package mem_ctrl_pkg;

  typedef logic [31:0] data_type_t;

  localparam logic [31:0] IoAddr   = 32'h0003_0000;
  localparam data_type_t  ZeroWord = 32'h0000_0000;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRead  = 2'd1;
  localparam logic [1:0] StWrite = 2'd2;

  localparam logic [1:0] SelNone  = 2'd0;
  localparam logic [1:0] SelLsb   = 2'd1;
  localparam logic [1:0] SelRob   = 2'd2;
  localparam logic [1:0] SelFetch = 2'd3;

  // Any byte count other than 1 or 2 is served as a full word.
  function automatic logic [2:0] norm_size(input logic [5:0] size);
    case (size)
      6'd1:    return 3'd1;
      6'd2:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_byte_assemble.sv
// Inserts one RAM byte into the read word and produces the sign/zero-extended load result.
module mem_byte_assemble
  import mem_ctrl_pkg::*;
(
  input  data_type_t  word_i,
  input  logic [7:0]  byte_i,
  input  logic [1:0]  lane_i,
  input  logic [2:0]  size_i,
  input  logic        signed_i,
  output data_type_t  word_o,
  output data_type_t  ext_o
);

  always_comb begin
    word_o = word_i;
    word_o[{lane_i, 3'b000} +: 8] = byte_i;
  end

  always_comb begin
    case (size_i)
      3'd1:    ext_o = {{24{signed_i & word_o[7]}}, word_o[7:0]};
      3'd2:    ext_o = {{16{signed_i & word_o[15]}}, word_o[15:0]};
      default: ext_o = word_o;
    endcase
  end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial RAM controller arbitrating ROB stores, LSB loads and instruction fetches.
// Optional MEM_CTRL_IO_STALL_EN holds I/O-space writes while the UART buffer is full.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter logic [31:0] IO_ADDR = IoAddr
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              in_lsb_flag,
  input  logic [5:0]        in_lsb_size,
  input  logic              in_lsb_signed,
  input  logic [ADDR_W-1:0] in_lsb_address,
  output logic              out_lsb_flag,
  output logic [31:0]       out_lsb_data,
  input  logic              in_rob_flag,
  input  logic [5:0]        in_rob_size,
  input  logic [ADDR_W-1:0] in_rob_address,
  input  logic [31:0]       in_rob_data,
  output logic              out_rob_done,
  input  logic              in_fetch_flag,
  input  logic [ADDR_W-1:0] in_fetch_pc,
  output logic              out_fetch_flag,
  output logic [31:0]       out_fetch_inst,
  input  logic              in_rob_xbp,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full
);

  logic [1:0]        state_q, state_d, sel_q, sel_d;
  logic [ADDR_W-1:0] base_q, base_d, mem_a_q, mem_a_d;
  logic [2:0]        size_q, size_d, cnt_q, cnt_d;
  logic              signed_q, signed_d, mem_wr_q, mem_wr_d;
  data_type_t        wdata_q, wdata_d, buf_q, buf_d;
  logic [7:0]        mem_dout_q, mem_dout_d;
  data_type_t        lsb_data_q, lsb_data_d, fetch_inst_q, fetch_inst_d;
  logic              lsb_flag_q, lsb_flag_d, rob_done_q, rob_done_d;
  logic              fetch_flag_q, fetch_flag_d;
  logic              rob_req, lsb_req, fetch_req, io_stall, store_block;
  logic [1:0]        lane;
  data_type_t        asm_word, asm_ext;

`ifdef MEM_CTRL_IO_STALL_EN
  logic base_is_io, req_is_io;
  assign base_is_io  = (base_q == ADDR_W'(IO_ADDR)) || (base_q == ADDR_W'(IO_ADDR + 32'd4));
  assign req_is_io   = (in_rob_address == ADDR_W'(IO_ADDR)) ||
                       (in_rob_address == ADDR_W'(IO_ADDR + 32'd4));
  assign io_stall    = (state_q == StWrite) && base_is_io && io_buffer_full;
  assign store_block = req_is_io && io_buffer_full;
`else
  logic unused_io;
  assign unused_io   = io_buffer_full ^ (^IO_ADDR);
  assign io_stall    = 1'b0;
  assign store_block = 1'b0;
`endif

  // A client is not re-accepted while its own done pulse is still high.
  assign rob_req   = in_rob_flag && !rob_done_q && !store_block;
  assign lsb_req   = in_lsb_flag && !lsb_flag_q;
  assign fetch_req = in_fetch_flag && !fetch_flag_q;
  assign lane      = 2'(cnt_q - 3'd1);

  mem_byte_assemble u_asm (
    .word_i  (buf_q),
    .byte_i  (mem_din),
    .lane_i  (lane),
    .size_i  (size_q),
    .signed_i(signed_q),
    .word_o  (asm_word),
    .ext_o   (asm_ext)
  );

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    base_d       = base_q;
    size_d       = size_q;
    signed_d     = signed_q;
    cnt_d        = cnt_q;
    wdata_d      = wdata_q;
    buf_d        = buf_q;
    mem_a_d      = mem_a_q;
    mem_wr_d     = mem_wr_q;
    mem_dout_d   = mem_dout_q;
    lsb_data_d   = lsb_data_q;
    fetch_inst_d = fetch_inst_q;
    lsb_flag_d   = 1'b0;
    rob_done_d   = 1'b0;
    fetch_flag_d = 1'b0;
    case (state_q)
      StIdle: begin
        mem_wr_d = 1'b0;
        if (!in_rob_xbp && (rob_req || lsb_req || fetch_req)) begin
          cnt_d = 3'd0;
          buf_d = ZeroWord;
          if (rob_req) begin
            state_d    = StWrite;
            sel_d      = SelRob;
            base_d     = in_rob_address;
            size_d     = norm_size(in_rob_size);
            wdata_d    = in_rob_data;
            mem_a_d    = in_rob_address;
            mem_dout_d = in_rob_data[7:0];
            mem_wr_d   = 1'b1;
          end else if (lsb_req) begin
            state_d  = StRead;
            sel_d    = SelLsb;
            base_d   = in_lsb_address;
            size_d   = norm_size(in_lsb_size);
            signed_d = in_lsb_signed;
            mem_a_d  = in_lsb_address;
          end else begin
            state_d  = StRead;
            sel_d    = SelFetch;
            base_d   = in_fetch_pc;
            size_d   = 3'd4;
            signed_d = 1'b0;
            mem_a_d  = in_fetch_pc;
          end
        end
      end
      StRead: begin
        if (in_rob_xbp) begin
          state_d = StIdle;
          sel_d   = SelNone;
        end else begin
          // cnt counts addresses issued; the byte arriving now belongs to lane cnt-1.
          if (cnt_q != 3'd0) buf_d = asm_word;
          if (cnt_q == size_q) begin
            state_d = StIdle;
            sel_d   = SelNone;
            if (sel_q == SelFetch) begin
              fetch_flag_d = 1'b1;
              fetch_inst_d = asm_word;
            end else begin
              lsb_flag_d = 1'b1;
              lsb_data_d = asm_ext;
            end
          end else begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q + 3'd1 < size_q) mem_a_d = mem_a_q + ADDR_W'(1);
          end
        end
      end
      StWrite: begin
        if (!io_stall) begin
          if (cnt_q + 3'd1 < size_q) begin
            cnt_d      = cnt_q + 3'd1;
            mem_a_d    = mem_a_q + ADDR_W'(1);
            mem_dout_d = 8'(wdata_q >> {cnt_q + 3'd1, 3'b000});
          end else begin
            mem_wr_d   = 1'b0;
            rob_done_d = 1'b1;
            state_d    = StIdle;
            sel_d      = SelNone;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      sel_q        <= SelNone;
      base_q       <= '0;
      size_q       <= 3'd0;
      signed_q     <= 1'b0;
      cnt_q        <= 3'd0;
      wdata_q      <= ZeroWord;
      buf_q        <= ZeroWord;
      mem_a_q      <= '0;
      mem_wr_q     <= 1'b0;
      mem_dout_q   <= 8'h00;
      lsb_data_q   <= ZeroWord;
      fetch_inst_q <= ZeroWord;
      lsb_flag_q   <= 1'b0;
      rob_done_q   <= 1'b0;
      fetch_flag_q <= 1'b0;
    end else if (rdy) begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      base_q       <= base_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      cnt_q        <= cnt_d;
      wdata_q      <= wdata_d;
      buf_q        <= buf_d;
      mem_a_q      <= mem_a_d;
      mem_wr_q     <= mem_wr_d;
      mem_dout_q   <= mem_dout_d;
      lsb_data_q   <= lsb_data_d;
      fetch_inst_q <= fetch_inst_d;
      lsb_flag_q   <= lsb_flag_d;
      rob_done_q   <= rob_done_d;
      fetch_flag_q <= fetch_flag_d;
    end
  end

  // While stalled mid-read, re-present the address whose byte is still owed so
  // it is back on mem_din when rdy returns.
  always_comb begin
    mem_a = mem_a_q;
    if (!rdy && state_q == StRead && cnt_q != 3'd0) begin
      mem_a = base_q + ADDR_W'(cnt_q) - ADDR_W'(1);
    end
  end

  assign mem_wr         = mem_wr_q && rdy && !io_stall;
  assign mem_dout       = mem_dout_q;
  assign out_lsb_flag   = lsb_flag_q;
  assign out_lsb_data   = lsb_data_q;
  assign out_rob_done   = rob_done_q;
  assign out_fetch_flag = fetch_flag_q;
  assign out_fetch_inst = fetch_inst_q;

endmodule
